// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the unified memory-port arbiter.
//   arb_state_t : sequencer states (IDLE -> REQ -> RESP -> IDLE)
//   OWN_IF/OWN_D: owner of the outstanding transaction
//   mem_cmd_t   : registered memory command (we, be, addr, wdata)
//   timer_width : watchdog counter width for a given limit (minimum 1)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_timer.sv
// arb_timer: watchdog counter for one memory access.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart counting from 0 (new grant)
//   enable     : count this cycle (waiting for memory, no ack)
//   limit      : cycles allowed; 0 disables the watchdog
//   expired    : this is the last allowed waiting cycle and it is unacked
module arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + W'(1);
    end

    // cnt equals the index of the current REQ cycle, so firing at limit-1
    // keeps the request up for exactly 'limit' cycles.
    assign expired = enable && (limit != '0) && (cnt == limit - W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch
// and load/store. One outstanding access, round-robin under contention,
// watchdog abort after TIMEOUT cycles in REQ (0 disables it).
//   if_req/if_addr             -> fetch request;   if_ack/if_rdata/if_err <- completion
//   d_req/d_we/d_be/d_addr/d_wdata -> data request; d_ack/d_rdata/d_err   <- completion
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata -> registered memory command
//   mem_ack/mem_rdata          <- memory completion (looked at only in REQ)
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int            TW    = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    arb_state_t  state, state_n;
    logic        owner, last_owner;
    logic        grant_vld, grant;
    mem_cmd_t    cmd, grant_cmd;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        tmr_en, expired;

    assign mem_we    = cmd.we;
    assign mem_be    = cmd.be;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    assign tmr_en = (state == ARB_REQ) && !mem_ack;

    arb_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_vld),
        .enable  (tmr_en),
        .limit   (LIMIT),
        .expired (expired)
    );

    // State register plus the registers it sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_D;
            cmd        <= '0;
            mem_req    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state   <= state_n;
            mem_req <= (state_n == ARB_REQ);
            if (grant_vld) begin
                owner      <= grant;
                last_owner <= grant;
                cmd        <= grant_cmd;
            end
            // Ack is checked first so it wins over a same-cycle expiry.
            if (state == ARB_REQ && mem_ack) begin
                rdata_q <= cmd.we ? 32'h0 : mem_rdata;
                err_q   <= 1'b0;
            end else if (expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Next state and arbitration.
    always_comb begin
        state_n   = state;
        grant_vld = 1'b0;
        grant     = OWN_IF;
        grant_cmd = '0;
        case (state)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    grant_vld = 1'b1;
                    // Contended: hand the port to whoever did not go last.
                    grant     = (if_req && d_req) ? ~last_owner : d_req;
                    state_n   = ARB_REQ;
                end
            end
            ARB_REQ:  if (mem_ack || expired) state_n = ARB_RESP;
            ARB_RESP: state_n = ARB_IDLE;
            default:  state_n = ARB_IDLE;
        endcase
        if (grant == OWN_D) begin
            grant_cmd.we    = d_we;
            grant_cmd.be    = d_be;
            grant_cmd.addr  = d_addr;
            grant_cmd.wdata = d_wdata;
        end else begin
            grant_cmd.we    = 1'b0;
            grant_cmd.be    = 4'hF;
            grant_cmd.addr  = if_addr;
            grant_cmd.wdata = '0;
        end
    end

    // Completion outputs decode only registered state.
    always_comb begin
        if_ack   = 1'b0;
        if_rdata = '0;
        if_err   = 1'b0;
        d_ack    = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        if (state == ARB_RESP) begin
            if (owner == OWN_IF) begin
                if_ack   = 1'b1;
                if_rdata = rdata_q;
                if_err   = err_q;
            end else begin
                d_ack    = 1'b1;
                d_rdata  = rdata_q;
                d_err    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus against a timeline model.
// For each grant the model fixes, from the arbitration rules and the chosen
// memory delay, the cycle window in which mem_req is high and the cycle of the
// completion pulse; every cycle's outputs are compared against that timeline.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Requesters: index 0 = fetch, 1 = data.
    bit          req_m [2];
    bit          we_m [2];
    logic [3:0]  be_m [2];
    logic [31:0] addr_m [2], wdata_m [2];
    int          rem [2], pct [2], raise_cyc [2];
    bit          fix [2], fix_we [2];
    logic [3:0]  fix_be [2];
    logic [31:0] fix_addr [2], fix_wdata [2];

    assign if_req  = req_m[0];
    assign if_addr = addr_m[0];
    assign d_req   = req_m[1];
    assign d_we    = we_m[1];
    assign d_be    = be_m[1];
    assign d_addr  = addr_m[1];
    assign d_wdata = wdata_m[1];

    // Model state.
    int          c, g, n, dly, dfix;
    bit          busy, who, last, mdata_fix, chk_en;
    bit          cw, pw;
    logic [3:0]  cbe, pbe;
    logic [31:0] caddr, cwdata, paddr, pwdata, x_rdata;
    bit          x_err;
    int          n_cmp, n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cycle %0d: got %h want %h", nm, c, act, exp);
        end
    endtask

    // One clock: retire/abort in the model, drive memory and requesters for
    // this cycle, then decide a grant if the arbiter is free.
    task automatic tick(input bit rst);
        @(posedge clk);
        #1;
        c++;
        if (busy && c - 1 == g + n + 1) begin
            busy = 0;
            req_m[who] = 0;
        end
        if (reset) begin
            busy = 0; last = 1;
            cw = 0; cbe = '0; caddr = '0; cwdata = '0;
        end else if (busy && c == g + 1) begin
            cw = pw; cbe = pbe; caddr = paddr; cwdata = pwdata;
        end
        reset = rst;

        mem_rdata = $urandom;
        if (busy && c >= g + 1 && c <= g + n) begin
            mem_ack = (c == g + 1 + dly);
            if (mem_ack) begin
                if (mdata_fix) mem_rdata = 32'hDEADBEEF;
                x_rdata = cw ? 32'h0 : mem_rdata;
                x_err   = 0;
            end
        end else begin
            mem_ack = 1'($urandom_range(1));
        end

        for (int m = 0; m < 2; m++) begin
            if (!req_m[m] && rem[m] > 0 && $urandom_range(99) < pct[m]) begin
                rem[m]--;
                raise_cyc[m] = c;
                req_m[m] = 1;
                if (fix[m]) begin
                    we_m[m] = fix_we[m]; be_m[m] = fix_be[m];
                    addr_m[m] = fix_addr[m]; wdata_m[m] = fix_wdata[m];
                end else begin
                    we_m[m] = (m == 1) && ($urandom_range(1) == 1);
                    be_m[m] = 4'($urandom); addr_m[m] = $urandom; wdata_m[m] = $urandom;
                end
            end
        end

        if (!reset && !busy && (req_m[0] || req_m[1])) begin
            who  = (req_m[0] && req_m[1]) ? !last : req_m[1];
            last = who;
            g    = c;
            busy = 1;
            if (who) begin
                pw = we_m[1]; pbe = be_m[1]; paddr = addr_m[1]; pwdata = wdata_m[1];
            end else begin
                pw = 0; pbe = 4'hF; paddr = addr_m[0]; pwdata = '0;
            end
            dly = (dfix >= 0) ? dfix : (($urandom_range(7) == 0) ? 1000 : int'($urandom_range(5)));
            if (dly >= TO) begin
                n = TO; x_rdata = '0; x_err = 1;
            end else begin
                n = dly + 1;
            end
        end
    endtask

    task automatic run_until_ack(input int lim, output bit ai, output bit ad);
        ai = 0; ad = 0;
        for (int k = 0; k < lim && !ai && !ad; k++) begin
            tick(0);
            ai = if_ack; ad = d_ack;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (busy || req_m[0] || req_m[1]); k++) tick(0);
        chk("drain_idle", {31'h0, busy | req_m[0] | req_m[1]}, 0);
    endtask

    // Per-cycle comparison against the model timeline.
    always @(negedge clk) begin
        bit ra, ia, da;
        if (chk_en) begin
            ra = busy && c >= g + 1 && c <= g + n;
            ia = busy && c == g + n + 1 && !who;
            da = busy && c == g + n + 1 && who;
            chk("mem_req", mem_req, ra);
            chk("mem_we", mem_we, cw);
            chk("mem_be", mem_be, cbe);
            chk("mem_addr", mem_addr, caddr);
            chk("mem_wdata", mem_wdata, cwdata);
            chk("if_ack", if_ack, ia);
            chk("if_rdata", if_rdata, ia ? x_rdata : 32'h0);
            chk("if_err", if_err, ia & x_err);
            chk("d_ack", d_ack, da);
            chk("d_rdata", d_rdata, da ? x_rdata : 32'h0);
            chk("d_err", d_err, da & x_err);
        end
    end

    initial begin
        bit ai, ad;
        int prev, cnt;
        reset = 1; mem_ack = 0; mem_rdata = '0;
        c = 0; busy = 0; last = 1; chk_en = 0; n_cmp = 0; n_bad = 0;
        dfix = -1; mdata_fix = 0; g = 0; n = 0; who = 0;
        cw = 0; cbe = '0; caddr = '0; cwdata = '0; x_rdata = '0; x_err = 0;
        for (int m = 0; m < 2; m++) begin
            req_m[m] = 0; we_m[m] = 0; be_m[m] = '0; addr_m[m] = '0; wdata_m[m] = '0;
            rem[m] = 0; pct[m] = 0; fix[m] = 0; raise_cyc[m] = 0;
        end

        // Reset state.
        tick(1);
        chk_en = 1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // Single load, memory acks 3 cycles after mem_req rises.
        rem[1] = 1; pct[1] = 100; fix[1] = 1; fix_we[1] = 0; fix_be[1] = 4'hF;
        fix_addr[1] = 32'h40; fix_wdata[1] = '0; dfix = 3; mdata_fix = 1;
        run_until_ack(20, ai, ad);
        chk("ld_d_ack", ad, 1);
        chk("ld_if_ack", ai, 0);
        chk("ld_latency", c - raise_cyc[1], 5);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);
        chk("ld_err", d_err, 0);
        mdata_fix = 0;
        drain();

        // Continuous contention after reset, zero-wait memory.
        tick(1);
        rem[0] = 8; rem[1] = 8; pct[0] = 100; pct[1] = 100; fix[1] = 0; dfix = 0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            run_until_ack(10, ai, ad);
            chk("rr_ack", ai | ad, 1);
            chk("rr_owner", ad, k % 2);
            if (k > 0) chk("rr_spacing", c - prev, 3);
            prev = c;
        end
        rem[0] = 0; rem[1] = 0;
        drain();

        // Store: command fields stable through REQ, no read data back.
        rem[1] = 1; fix[1] = 1; fix_we[1] = 1; fix_be[1] = 4'b0011;
        fix_addr[1] = 32'h80; fix_wdata[1] = 32'h12345678; dfix = 2;
        cnt = 0; ad = 0;
        for (int k = 0; k < 20 && !ad; k++) begin
            tick(0);
            if (mem_req) begin
                cnt++;
                chk("st_we", mem_we, 1);
                chk("st_be", mem_be, 4'b0011);
                chk("st_wdata", mem_wdata, 32'h12345678);
            end
            if (d_ack) begin
                ad = 1;
                chk("st_rdata", d_rdata, 0);
            end
        end
        chk("st_acked", ad, 1);
        chk("st_req_cycles", cnt, 3);
        drain();

        // Fetch never acked: watchdog abort.
        rem[0] = 1; pct[0] = 100; fix[0] = 1; fix_addr[0] = 32'h100; dfix = 1000;
        cnt = 0; ai = 0;
        for (int k = 0; k < 20 && !ai; k++) begin
            tick(0);
            if (mem_req) begin
                cnt++;
                chk("to_addr", mem_addr, 32'h100);
            end
            if (if_ack) begin
                ai = 1;
                chk("to_err", if_err, 1);
                chk("to_rdata", if_rdata, 0);
            end
        end
        chk("to_acked", ai, 1);
        chk("to_req_cycles", cnt, 4);
        tick(0);
        chk("to_idle_req", mem_req, 0);
        chk("to_idle_ack", if_ack, 0);
        fix[0] = 0;
        drain();

        // Reset in REQ drops the access; next contended grant is IF.
        rem[1] = 1; fix[1] = 1; fix_we[1] = 0; fix_addr[1] = 32'h200; dfix = 1000;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 2; k++) begin
            tick(0);
            if (mem_req) cnt++;
        end
        chk("rq_reached_req", cnt, 2);
        tick(1);
        rem[0] = 1; pct[0] = 100; dfix = -1;
        tick(0);
        chk("rq_mem_req", mem_req, 0);
        chk("rq_d_ack", d_ack, 0);
        run_until_ack(20, ai, ad);
        chk("rq_first_if", ai, 1);
        chk("rq_first_not_d", ad, 0);
        fix[1] = 0;
        drain();

        // Random traffic with occasional resets.
        for (int seg = 0; seg < 6; seg++) begin
            rem[0] = 1000; rem[1] = 1000;
            pct[0] = $urandom_range(100, 10); pct[1] = $urandom_range(100, 10);
            for (int k = 0; k < 500; k++) tick($urandom_range(149) == 0);
        end
        rem[0] = 0; rem[1] = 0;
        drain();
        tick(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one unified memory port between the core's instruction-fetch path and its load/store path. It sits between the datapath (`pc`/`instr`, `aluout`/`writedata`/`readdata`) and a single-ported memory with variable-latency acknowledge. It holds one outstanding transaction at a time, grants round-robin under contention, and aborts any access that exceeds a watchdog limit.

## Interface
Parameters:
- `TIMEOUT`, default 255: max cycles in REQ before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `if_rdata`  out  32  fetched word, valid while `if_ack`.
- `if_err`  out  1  fetch aborted by watchdog, valid while `if_ack`.
- `d_req`  in  1  data request; fields held stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_ack`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  32  load data, valid while `d_ack`; 0 for stores.
- `d_err`  out  1  data access aborted, valid while `d_ack`.
- `mem_req`  out  1  memory request, held until `mem_ack` or abort.
- `mem_we`, `mem_be[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  out  registered command fields.
- `mem_ack`  in  1  memory completion, sampled only while `mem_req`=1.
- `mem_rdata`  in  32  memory read data, valid with `mem_ack`.

## Operation
- States: IDLE, REQ, RESP. Registers: `owner` (IF/D), `last_owner`, `cnt`, `rdata_q`, `err_q`.
- IDLE: only one of `if_req`/`d_req` set -> grant it. Both set -> grant the one ≠ `last_owner`. On grant: latch command fields into `mem_*`, set `owner`, `last_owner`<=grantee, `cnt`<=0, go to REQ. Fetch drives `mem_we`=0, `mem_be`=4'hF, `mem_wdata`=0.
- REQ: `mem_req`=1. `mem_ack`=1 -> `rdata_q`<=(`mem_we` ? 0 : `mem_rdata`), `err_q`<=0, go to RESP. Otherwise `cnt`++; when `TIMEOUT`≠0 and `cnt`==`TIMEOUT`-1 with no ack -> `rdata_q`<=0, `err_q`<=1, go to RESP. Ack wins over timeout when both occur in the same cycle.
- RESP: owner's `*_ack`=1, `*_rdata`=`rdata_q`, `*_err`=`err_q`; the non-owner's outputs stay 0. Requests are ignored this cycle; go to IDLE.
- A requester that keeps `req` high in the cycle after its ack is issuing a new request, arbitrated normally in IDLE.
- `mem_*` command fields hold their last value outside REQ. `*_rdata` is 0 whenever the matching `*_ack` is 0.

## Timing
- Reset values: state IDLE, `mem_req`=0, all `mem_*`=0, `if_ack`=`d_ack`=0, `if_err`=`d_err`=0, `*_rdata`=0, `last_owner`=D (first contended grant goes to IF), `cnt`=0.
- Zero-wait memory: request sampled in IDLE at cycle 0, `mem_req` high in cycle 1, `mem_ack` in cycle 1, ack pulse in cycle 2, IDLE in cycle 3. Request-to-ack latency = 2 + wait cycles. Throughput is one access per 3 cycles.
- Watchdog: with no `mem_ack`, `mem_req` is high for exactly `TIMEOUT` cycles, then the ack pulse carries err=1.
- Reset asserted in any state aborts the transaction: next cycle all outputs are at reset values. No ack is issued for the dropped access.
- All outputs are registered except `*_ack`/`*_rdata`/`*_err`, which are decoded from state and registered `owner`/`rdata_q`/`err_q` with no input-to-output combinational path.

## Structure
- `consts.v` gains: state encodings `ARB_IDLE`/`ARB_REQ`/`ARB_RESP` (2 bits), owner encodings `OWN_IF`=1'b0 and `OWN_D`=1'b1.
- One sub-module, `arb_timer`: watchdog counter with inputs clear, enable, and limit, and a `expired` output. Width is $clog2(TIMEOUT+1), minimum 1.

## Test plan
- Single load, memory acks 3 cycles after `mem_req` rises, `mem_rdata`=32'hDEADBEEF -> `d_ack` pulses 5 cycles after `d_req`, `d_rdata`=32'hDEADBEEF, `d_err`=0, `if_ack` stays 0.
- `if_req` and `d_req` both held high continuously after reset with zero-wait memory -> grants alternate IF, D, IF, D; each ack arrives 3 cycles after the previous one.
- Store with `d_be`=4'b0011, `d_wdata`=32'h12345678 -> `mem_we`=1, `mem_be`=4'b0011, and `mem_wdata` match the store for the whole REQ phase; `d_rdata`=0.
- `TIMEOUT`=4, memory never acks fetch at 32'h100 -> `mem_req` high exactly 4 cycles, `if_ack`=1 with `if_err`=1 and `if_rdata`=0, then IDLE.
- `reset` pulsed while in REQ -> next cycle `mem_req`=0, no ack pulse; the next contended grant goes to IF.
- `mem_ack` arrives in the same cycle `cnt` hits `TIMEOUT`-1 -> normal completion with err=0 and the memory data returned.
